// File: rtl/vram_scanout_arbiter_if.sv
// Bus bundle between the VRAM scan-out arbiter and its GPU, VRAM and video-block neighbours.
// slave is the arbiter's view; master is the environment's view.
interface vram_scanout_arbiter_if #(
   parameter int unsigned ADDR_W = 19
);
   logic              enable;
   logic              gpu_req;
   logic [ADDR_W-1:0] gpu_addr;
   logic [23:0]       gpu_data;
   logic              gpu_gnt;
   logic [ADDR_W-1:0] mem_addr;
   logic [23:0]       mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [23:0]       mem_rdata;
   logic [23:0]       vid_data;
   logic              vid_en;
   logic              vid_rdy;
   logic              frame_start;
   logic              underrun;

   modport slave (
      input  enable, gpu_req, gpu_addr, gpu_data, mem_rdata, vid_rdy,
      output gpu_gnt, mem_addr, mem_wdata, mem_we, mem_re,
             vid_data, vid_en, frame_start, underrun
   );

   modport master (
      output enable, gpu_req, gpu_addr, gpu_data, mem_rdata, vid_rdy,
      input  gpu_gnt, mem_addr, mem_wdata, mem_we, mem_re,
             vid_data, vid_en, frame_start, underrun
   );
endinterface

// File: rtl/vram_scanout_arbiter.sv
// Shares a single-port framebuffer between GPU writes and HDMI scan-out reads,
// prefetching scan-out pixels into a small FIFO that feeds the video block.
module vram_scanout_arbiter #(
   parameter int unsigned H_RES      = 720,
   parameter int unsigned V_RES      = 480,
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned LOW_WM     = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   vram_scanout_arbiter_if.slave   bus
);
   localparam int unsigned FRAME_PIX = H_RES * V_RES;
   localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W     = PTR_W + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

   state_t            state, state_nxt;
   logic [23:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count, occ;
   logic [ADDR_W-1:0] scan_ptr;
   logic              inflight, vid_en_q, underrun_q;
   logic [23:0]       vid_data_q;

   logic              rd_ok, urgent, push, underrun_set;
   logic              gnt, we, re, fs, ven;
   logic [ADDR_W-1:0] addr;
   logic [23:0]       wdata, vdata;

   assign occ  = count + CNT_W'(inflight);
   assign push = inflight && (state != IDLE);

   // Next state, arbitration and video-side strobes
   always_comb begin
      state_nxt    = state;
      rd_ok        = 1'b0;
      urgent       = 1'b0;
      gnt          = 1'b0;
      we           = 1'b0;
      re           = 1'b0;
      fs           = 1'b0;
      ven          = 1'b0;
      underrun_set = 1'b0;
      addr         = '0;
      wdata        = '0;
      vdata        = vid_data_q;

      case (state)
         IDLE:    state_nxt = FILL;
         FILL:    if (count == CNT_W'(FIFO_DEPTH)) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
      if (!bus.enable) state_nxt = IDLE;

      rd_ok  = (state != IDLE) && (occ < CNT_W'(FIFO_DEPTH));
      urgent = rd_ok && (count <= CNT_W'(LOW_WM));

      // Outputs held low while reset is asserted, GPU grant included
      if (!rst) begin
         if (urgent || (rd_ok && !bus.gpu_req)) begin
            re   = 1'b1;
            addr = ADDR_W'(BASE_ADDR) + scan_ptr;
            fs   = (scan_ptr == '0);
         end else if (bus.gpu_req) begin
            gnt   = 1'b1;
            we    = 1'b1;
            addr  = bus.gpu_addr;
            wdata = bus.gpu_data;
         end

         // Video block keeps rdy up one cycle after en, so never strobe twice in a row
         ven          = (state == RUN) && bus.vid_rdy && (count != '0) && !vid_en_q;
         underrun_set = (state == RUN) && bus.vid_rdy && (count == '0) && !vid_en_q;
         if (ven) vdata = fifo_mem[rd_ptr];
      end
   end

   // State register and FIFO/scan bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         scan_ptr   <= '0;
         inflight   <= 1'b0;
         vid_en_q   <= 1'b0;
         vid_data_q <= '0;
         underrun_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= re;
         vid_en_q <= ven;
         if (ven) vid_data_q <= fifo_mem[rd_ptr];

         if (state == IDLE) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            scan_ptr   <= '0;
            underrun_q <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (ven)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, ven})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
            if (re) begin
               if (scan_ptr == ADDR_W'(FRAME_PIX - 1)) scan_ptr <= '0;
               else                                    scan_ptr <= scan_ptr + ADDR_W'(1);
            end
            if (underrun_set) underrun_q <= 1'b1;
         end
      end
   end

   // Prefetch storage, no reset needed: only read when count is non-zero
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.mem_rdata;
   end

   assign bus.gpu_gnt     = gnt;
   assign bus.mem_we      = we;
   assign bus.mem_re      = re;
   assign bus.mem_addr    = addr;
   assign bus.mem_wdata   = wdata;
   assign bus.frame_start = fs;
   assign bus.vid_en      = ven;
   assign bus.vid_data    = vdata;
   assign bus.underrun    = underrun_q;
endmodule
